reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 54 +++++
 rtl/reg_file_sb.sv | 122 ++++++++++++
 tb/tb_reg_file_sb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
// Holds the clear-sequencer state encoding and the default widths.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // True when an address refers to the hardwired zero entry.
  function automatic logic is_zero_entry(input logic zero_reg_en, input logic addr_is_zero);
    return zero_reg_en && addr_is_zero;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit array: tracks which entries have an outstanding reservation.
// Writes clear a bit, accepted reserves set it, and the clear sweep zeroes one bit per cycle.
module rf_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              rsv_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic              pend1_o,
  output logic              pend2_o,
  output logic              rsv_ok_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  assign pend1_o = pend_q[rd_addr1_i];
  assign pend2_o = pend_q[rd_addr2_i];

  // A write landing on the entry this cycle frees it for a new reservation.
  assign rsv_ok_o = !busy_i && (!pend_q[rsv_addr_i] || (wr_i && (wr_addr_i == rsv_addr_i)));

  // Per-entry next state: set wins over a same-cycle write; entry 0 may be hardwired clear.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++) begin
      pend_d[i] = !(ZR && (i == 0))
                  && !(busy_i && (clr_idx_i == ADDR_W'(i)))
                  && ((!busy_i && rsv_i && rsv_ok_o && (rsv_addr_i == ADDR_W'(i)))
                      || (pend_q[i] && !(!busy_i && wr_i && (wr_addr_i == ADDR_W'(i)))));
    end
  end

  // Pending-bit storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= {DEPTH{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with reservation scoreboard, write bypass
// and a one-entry-per-cycle clear sequencer.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddrR1,
  input  logic [ADDR_W-1:0] rdAddrR2,
  output logic [DATA_W-1:0] rdDataR1,
  output logic [DATA_W-1:0] rdDataR2,
  output logic              rdPendR1,
  output logic              rdPendR2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvAddr,
  output logic              rsvOk,
  input  logic              clr,
  output logic              busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam bit                ZR        = (ZERO_REG != 0);
  localparam bit                BP        = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  rf_state_e         state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_en_s;
  logic byp1_s;
  logic byp2_s;
  logic pend1_s;
  logic pend2_s;

  assign busy    = busy_q;
  assign wr_en_s = wr && !busy_q && !is_zero_entry(ZR, wrAddr == ZERO_ADDR);
  assign byp1_s  = BP && wr_en_s && (wrAddr == rdAddrR1);
  assign byp2_s  = BP && wr_en_s && (wrAddr == rdAddrR2);

  // Read ports: forwarded write data first, then hardwired zero, then storage.
  assign rdDataR1 = byp1_s ? wrData
                  : (is_zero_entry(ZR, rdAddrR1 == ZERO_ADDR) ? {DATA_W{1'b0}} : mem_q[rdAddrR1]);
  assign rdDataR2 = byp2_s ? wrData
                  : (is_zero_entry(ZR, rdAddrR2 == ZERO_ADDR) ? {DATA_W{1'b0}} : mem_q[rdAddrR2]);
  assign rdPendR1 = byp1_s ? 1'b0 : pend1_s;
  assign rdPendR2 = byp2_s ? 1'b0 : pend2_s;

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .busy_i    (busy_q),
    .clr_idx_i (idx_q),
    .wr_i      (wr),
    .wr_addr_i (wrAddr),
    .rsv_i     (rsv),
    .rsv_addr_i(rsvAddr),
    .rd_addr1_i(rdAddrR1),
    .rd_addr2_i(rdAddrR2),
    .pend1_o   (pend1_s),
    .pend2_o   (pend2_s),
    .rsv_ok_o  (rsvOk)
  );

  // Clear sequencer; busy is registered alongside the state it mirrors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      idx_q   <= ZERO_ADDR;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            idx_q   <= ZERO_ADDR;
          end
        end
        CLEAR: begin
          idx_q <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= ZERO_ADDR;
        end
      endcase
    end
  end

  // Data storage: sweep zeroing while busy, otherwise the accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (busy_q) begin
      mem_q[idx_q] <= {DATA_W{1'b0}};
    end else if (wr_en_s) begin
      mem_q[wrAddr] <= wrData;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reads, bypass, zero entry, reservations,
// clear sweep timing and reset abort.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;
  logic [2:0]  rdAddrR1;
  logic [2:0]  rdAddrR2;
  logic [15:0] rdDataR1;
  logic [15:0] rdDataR2;
  logic        rdPendR1;
  logic        rdPendR2;
  logic        rsv;
  logic [2:0]  rsvAddr;
  logic        rsvOk;
  logic        clr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  reg_file_sb #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .rdAddrR1(rdAddrR1),
    .rdAddrR2(rdAddrR2),
    .rdDataR1(rdDataR1),
    .rdDataR2(rdDataR2),
    .rdPendR1(rdPendR1),
    .rdPendR2(rdPendR2),
    .rsv     (rsv),
    .rsvAddr (rsvAddr),
    .rsvOk   (rsvOk),
    .clr     (clr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] fill_val;

  initial begin
    rst = 1'b1; wr = 1'b0; wrAddr = 3'd0; wrData = 16'h0000;
    rdAddrR1 = 3'd0; rdAddrR2 = 3'd0; rsv = 1'b0; rsvAddr = 3'd0; clr = 1'b0;
    #12;
    chk("rst_data1", {16'h0, rdDataR1}, 32'h0);
    chk("rst_pend1", {31'h0, rdPendR1}, 32'h0);
    chk("rst_busy",  {31'h0, busy},     32'h0);
    chk("rst_rsvok", {31'h0, rsvOk},    32'h1);
    rst = 1'b0;
    tick();

    // write r3 then read it back
    wr = 1'b1; wrAddr = 3'd3; wrData = 16'h1234;
    tick();
    wr = 1'b0; rdAddrR1 = 3'd3;
    #1;
    chk("r3_data", {16'h0, rdDataR1}, 32'h1234);
    chk("r3_pend", {31'h0, rdPendR1}, 32'h0);

    // same-cycle bypass on R2
    wr = 1'b1; wrAddr = 3'd5; wrData = 16'hBEEF; rdAddrR2 = 3'd5;
    #1;
    chk("byp_r5", {16'h0, rdDataR2}, 32'hBEEF);
    tick();
    wr = 1'b0;
    #1;
    chk("stored_r5", {16'h0, rdDataR2}, 32'hBEEF);

    // entry 0 is hardwired to zero
    wr = 1'b1; wrAddr = 3'd0; wrData = 16'hFFFF; rdAddrR1 = 3'd0;
    #1;
    chk("r0_nobyp", {16'h0, rdDataR1}, 32'h0);
    tick();
    wr = 1'b0;
    #1;
    chk("r0_after", {16'h0, rdDataR1}, 32'h0);

    // reserve r2, second reserve refused, write clears pending
    rsv = 1'b1; rsvAddr = 3'd2;
    #1;
    chk("rsv2_ok", {31'h0, rsvOk}, 32'h1);
    tick();
    rsv = 1'b0; rdAddrR1 = 3'd2;
    #1;
    chk("rsv2_pend", {31'h0, rdPendR1}, 32'h1);
    rsv = 1'b1;
    #1;
    chk("rsv2_again", {31'h0, rsvOk}, 32'h0);
    rsv = 1'b0;
    wr = 1'b1; wrAddr = 3'd2; wrData = 16'h0007;
    #1;
    chk("wr2_byp_pend", {31'h0, rdPendR1}, 32'h0);
    chk("wr2_rsvok",    {31'h0, rsvOk},    32'h1);
    tick();
    wr = 1'b0;
    #1;
    chk("wr2_pend", {31'h0, rdPendR1}, 32'h0);
    chk("wr2_data", {16'h0, rdDataR1}, 32'h0007);

    // write and reserve r4 together
    wr = 1'b1; wrAddr = 3'd4; wrData = 16'h0444; rsv = 1'b1; rsvAddr = 3'd4;
    tick();
    wr = 1'b0; rsv = 1'b0; rdAddrR1 = 3'd4; rsvAddr = 3'd4;
    #1;
    chk("wr_rsv4_data", {16'h0, rdDataR1}, 32'h0444);
    chk("wr_rsv4_pend", {31'h0, rdPendR1}, 32'h1);
    chk("r4_rsvok",     {31'h0, rsvOk},    32'h0);

    // reserving entry 0 is accepted but sets nothing
    rsv = 1'b1; rsvAddr = 3'd0;
    #1;
    chk("rsv0_ok", {31'h0, rsvOk}, 32'h1);
    tick();
    rsv = 1'b0; rdAddrR2 = 3'd0;
    #1;
    chk("rsv0_pend", {31'h0, rdPendR2}, 32'h0);

    // fill r1..r7
    for (int i = 1; i < 8; i++) begin
      fill_val = 16'h1000 + 16'(i) * 16'h0111;
      wr = 1'b1; wrAddr = 3'(i); wrData = fill_val;
      tick();
    end
    wr = 1'b0; rdAddrR1 = 3'd7;
    #1;
    chk("fill_r7", {16'h0, rdDataR1}, 32'h1777);

    // clear sweep: busy for exactly 8 cycles, wr/rsv/clr ignored
    clr = 1'b1;
    tick();
    wr = 1'b1; wrAddr = 3'd1; wrData = 16'hDEAD; rsv = 1'b1; rsvAddr = 3'd3;
    rdAddrR1 = 3'd1;
    #1;
    chk("busy_nobyp", {16'h0, rdDataR1}, 32'h1111);
    chk("busy_rsvok", {31'h0, rsvOk},    32'h0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("busy_c%0d", k), {31'h0, busy}, 32'h1);
      tick();
    end
    wr = 1'b0; rsv = 1'b0; clr = 1'b0;
    #1;
    chk("busy_done", {31'h0, busy}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rdAddrR1 = 3'(a); rdAddrR2 = 3'(a);
      #1;
      chk($sformatf("clr_data%0d", a), {16'h0, rdDataR1}, 32'h0);
      chk($sformatf("clr_pend%0d", a), {31'h0, rdPendR2}, 32'h0);
    end
    rsvAddr = 3'd4;
    #1;
    chk("clr_rsvok4", {31'h0, rsvOk}, 32'h1);
    tick();
    chk("idle_stays", {31'h0, busy}, 32'h0);

    // reset in the middle of a sweep
    wr = 1'b1; wrAddr = 3'd6; wrData = 16'h00AA;
    tick();
    wr = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    rdAddrR1 = 3'd6; rsvAddr = 3'd6;
    #1;
    chk("mid_busy", {31'h0, busy},     32'h1);
    chk("mid_r6",   {16'h0, rdDataR1}, 32'h00AA);
    rst = 1'b1;
    #1;
    chk("abort_busy",  {31'h0, busy},     32'h0);
    chk("abort_r6",    {16'h0, rdDataR1}, 32'h0);
    chk("abort_rsvok", {31'h0, rsvOk},    32'h1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_busy", {31'h0, busy},     32'h0);
    chk("post_r6",   {16'h0, rdDataR1}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
